// File: rtl/ex_p2s_pkg.sv
// Shared frame constants and CRC-4 for the serial frame link (transmitter,
// receiver and bench model all use the same definitions).
package ex_p2s_pkg;

   localparam logic [3:0] PREAMBLE  = 4'hA;
   localparam logic [3:0] CRC_INIT  = 4'hF;
   localparam int unsigned FRAME_LEN = 25;
   localparam int unsigned BODY_LEN  = 21;

   // CRC over {rnw, addr, data}, seeded with CRC_INIT.
   function automatic logic [3:0] calc_crc4(input logic [16:0] b);
      logic [3:0] i;
      logic [3:0] c;
      i = CRC_INIT;
      c[0] = b[15]^b[11]^b[10]^b[9]^b[8]^b[6]^b[4]^b[3]^b[0]^i[2];
      c[1] = b[16]^b[15]^b[12]^b[8]^b[7]^b[6]^b[5]^b[3]^b[1]^b[0]^i[2]^i[3];
      c[2] = b[16]^b[13]^b[9]^b[8]^b[7]^b[6]^b[4]^b[2]^b[1]^i[0]^i[3];
      c[3] = b[14]^b[10]^b[9]^b[8]^b[7]^b[5]^b[3]^b[2]^i[1];
      return c;
   endfunction

endpackage

// File: rtl/ex_s2p.sv
// Serial-to-parallel frame receiver: hunts for the preamble, shifts in the
// 21-bit body, checks its CRC and keeps a saturating CRC error count.
module ex_s2p
   import ex_p2s_pkg::*;
#(
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sdata,
   output logic                 frame_valid,
   output logic                 rnw,
   output logic [7:0]           addr,
   output logic [7:0]           data,
   output logic                 crc_err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   typedef enum logic {HUNT, BODY} state_t;

   state_t      state;
   logic [3:0]  window;
   logic [20:0] body;
   logic [4:0]  cnt;
   logic [20:0] body_next;
   logic        crc_bad;

   // The last body bit is taken straight from sdata so outputs register on it.
   always_comb begin
      body_next = {body[19:0], sdata};
      crc_bad   = (calc_crc4(body_next[20:4]) != body_next[3:0]);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= HUNT;
         window      <= '0;
         body        <= '0;
         cnt         <= '0;
         frame_valid <= 1'b0;
         rnw         <= 1'b0;
         addr        <= '0;
         data        <= '0;
         crc_err     <= 1'b0;
         err_cnt     <= '0;
      end else begin
         frame_valid <= 1'b0;
         case (state)
            HUNT: begin
               window <= {window[2:0], sdata};
               if ({window[2:0], sdata} == PREAMBLE) begin
                  state <= BODY;
                  cnt   <= '0;
               end
            end
            BODY: begin
               body <= body_next;
               cnt  <= cnt + 5'd1;
               if (cnt == 5'(BODY_LEN - 1)) begin
                  frame_valid <= 1'b1;
                  rnw         <= body_next[20];
                  addr        <= body_next[19:12];
                  data        <= body_next[11:4];
                  crc_err     <= crc_bad;
                  if (crc_bad && (err_cnt != '1))
                     err_cnt <= err_cnt + ERR_CNT_W'(1);
                  state  <= HUNT;
                  window <= '0;
               end
            end
            default: state <= HUNT;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_s2p.sv
// Randomized bench for ex_s2p: a frame-level model predicts the edge and
// contents of every frame_valid pulse and the saturating error count.
module tb_ex_s2p;

   localparam int unsigned ERR_CNT_W = 8;
   localparam int ECNT_MAX = (1 << ERR_CNT_W) - 1;

   logic                 clk;
   logic                 rst_n;
   logic                 sdata;
   logic                 frame_valid;
   logic                 rnw;
   logic [7:0]           addr;
   logic [7:0]           data;
   logic                 crc_err;
   logic [ERR_CNT_W-1:0] err_cnt;

   ex_s2p #(.ERR_CNT_W(ERR_CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .sdata(sdata), .frame_valid(frame_valid),
      .rnw(rnw), .addr(addr), .data(data), .crc_err(crc_err), .err_cnt(err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic       r;
      logic [7:0] a;
      logic [7:0] d;
      logic       ce;
   } exp_t;

   exp_t q[$];
   int   edge_n = 0;
   logic rst_seen = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   logic       h_r;
   logic [7:0] h_a;
   logic [7:0] h_d;
   logic       h_ce;
   int         h_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h edge=%0d", tag, got, exp, edge_n);
      end
   endtask

   // Reference CRC as tap masks and parity; init terms folded in for seed 4'hF.
   function automatic logic [3:0] model_crc(input logic [16:0] b);
      logic [16:0] m [4];
      logic [3:0]  k;
      logic [3:0]  c;
      m[0] = 17'h08F59; m[1] = 17'h191EB; m[2] = 17'h123D6; m[3] = 17'h047AC;
      k = 4'b1001;
      for (int i = 0; i < 4; i++) c[i] = (^(b & m[i])) ^ k[i];
      return c;
   endfunction

   always @(posedge clk) begin
      edge_n   <= edge_n + 1;
      rst_seen <= !rst_n;
   end

   always @(negedge clk) begin
      logic exp_fv;
      exp_fv = 1'b0;
      if (rst_seen) begin
         q.delete();
         h_r = 1'b0; h_a = '0; h_d = '0; h_ce = 1'b0; h_cnt = 0;
      end else if (q.size() > 0 && q[0].cyc == edge_n) begin
         exp_t e;
         e = q.pop_front();
         exp_fv = 1'b1;
         h_r = e.r; h_a = e.a; h_d = e.d; h_ce = e.ce;
         if (e.ce && h_cnt < ECNT_MAX) h_cnt++;
      end
      check("frame_valid", frame_valid, exp_fv);
      check("rnw", rnw, h_r);
      check("addr", addr, h_a);
      check("data", data, h_d);
      check("crc_err", crc_err, h_ce);
      check("err_cnt", err_cnt, h_cnt);
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         sdata = 1'b0;
      end
   endtask

   task automatic send_frame(input logic r, input logic [7:0] a, input logic [7:0] d,
                             input logic [3:0] c);
      logic [24:0] s;
      exp_t e;
      s = {4'hA, r, a, d, c};
      for (int i = 24; i >= 0; i--) begin
         @(negedge clk);
         if (i == 24) begin
            // first bit sampled at the next edge; pulse visible 24 edges later
            e.cyc = edge_n + 1 + 24;
            e.r = r; e.a = a; e.d = d;
            e.ce = (c != model_crc({r, a, d}));
            q.push_back(e);
         end
         sdata = s[i];
      end
   endtask

   task automatic send_aborted(input logic r, input logic [7:0] a, input logic [7:0] d);
      logic [24:0] s;
      s = {4'hA, r, a, d, model_crc({r, a, d})};
      for (int i = 24; i >= 10; i--) begin
         @(negedge clk);
         sdata = s[i];
         if (i == 10) rst_n = 1'b0;
      end
      @(negedge clk);
      rst_n = 1'b1;
      sdata = 1'b0;
   endtask

   task automatic send_random(input bit corrupt);
      logic       r;
      logic [7:0] a;
      logic [7:0] d;
      logic [3:0] c;
      r = 1'($urandom);
      a = 8'($urandom);
      d = r ? 8'h5A : 8'($urandom);
      c = model_crc({r, a, d});
      if (corrupt) c = c ^ 4'($urandom_range(1, 15));
      send_frame(r, a, d, c);
   endtask

   initial begin
      rst_n = 1'b0;
      sdata = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle(4);

      send_frame(1'b0, 8'h00, 8'h00, 4'h9);
      idle(3);
      send_frame(1'b1, 8'h00, 8'h5A, 4'h0);
      idle(2);
      send_frame(1'b0, 8'h00, 8'h00, 4'h8);
      idle(1);
      send_frame(1'b0, 8'h00, 8'h00, 4'h9);
      send_frame(1'b1, 8'h00, 8'h5A, 4'h0);
      idle(30);
      check("err_cnt_after_one_bad", err_cnt, 1);

      send_aborted(1'b0, 8'h3C, 8'hA5);
      idle(2);
      send_frame(1'b0, 8'h12, 8'h34, model_crc({1'b0, 8'h12, 8'h34}));
      idle(3);

      // payload rich in 1010 patterns must not resync inside the body
      send_frame(1'b0, 8'hAA, 8'hA5, model_crc({1'b0, 8'hAA, 8'hA5}));
      send_frame(1'b0, 8'hAA, 8'hAA, 4'hA);

      for (int n = 0; n < 200; n++) begin
         send_random(bit'($urandom_range(0, 1)));
         idle($urandom_range(0, 3));
      end

      for (int n = 0; n < 300; n++) send_random(1'b1);
      idle(30);
      check("drain_queue_empty", q.size(), 0);
      check("err_cnt_saturated", err_cnt, ECNT_MAX);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
